// File: rtl/intra_chien_dispatch.sv
// intra_chien_dispatch
//   Takes one cluster of Multi chunk ELPs from the shared key-equation
//   stage and hands each chunk that actually needs a root search to a
//   single Chien search engine, one at a time. Chunks with no errors, a
//   zero ELP degree, or a KES failure are skipped. Skipped failures are
//   flagged in oChunkFail. When every chunk has been handled, a one-cycle
//   oClusterEnd pulse is issued.
//
//   Optional build macro: CS_ROOT_CHECK_EN
//     defined   - a completed search whose root count differs from the
//                 launched ELP degree marks that chunk uncorrectable.
//     undefined - iCSRootCount is ignored.
//
//   All outputs except oCSAvailable are registered. oCSAvailable is decoded
//   from the state register.

module intra_chien_dispatch #(
    parameter int Multi             = 2,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkIndexBits    = 1
) (
    input  logic                                                iClock,
    input  logic                                                iReset,
    // cluster hand-off from the shared KES stage
    input  logic                                                iIntraSharedKESEnd,
    input  logic [Multi-1:0]                                    iErroredChunk,
    input  logic [Multi-1:0]                                    iCorrectionFail,
    input  logic [Multi*MaxErrorCountBits-1:0]                  iClusterErrorCount,
    input  logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0]  iELPCoefficients,
    output logic                                                oCSAvailable,
    // Chien search engine launch / completion
    output logic                                                oCSStart,
    output logic [ChunkIndexBits-1:0]                           oCSChunkNumber,
    output logic [MaxErrorCountBits-1:0]                        oCSErrorCount,
    output logic [GaloisFieldDegree*ELPCoefficients-1:0]        oCSELP,
    input  logic                                                iCSReady,
    input  logic                                                iCSDone,
    input  logic [MaxErrorCountBits-1:0]                        iCSRootCount,
    // cluster completion
    output logic                                                oClusterEnd,
    output logic [Multi-1:0]                                    oChunkFail
);

    localparam int ElpWidth = GaloisFieldDegree * ELPCoefficients;
    localparam int CntWidth = MaxErrorCountBits;
    // The walk index has to reach Multi itself (the "all done" value), so it
    // is one count wider than a pure chunk index.
    localparam int IdxWidth = $clog2(Multi + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t                     state_q,       state_d;
    logic [IdxWidth-1:0]        idx_q,         idx_d;

    // cluster snapshot taken on the KES hand-off
    logic [Multi-1:0]           errored_q,     errored_d;
    logic [Multi-1:0]           kes_fail_q,    kes_fail_d;
    logic [Multi*CntWidth-1:0]  count_q,       count_d;
    logic [Multi*ElpWidth-1:0]  elp_q,         elp_d;

    // registered outputs
    logic [Multi-1:0]           chunk_fail_q,  chunk_fail_d;
    logic                       cs_start_q,    cs_start_d;
    logic                       cluster_end_q, cluster_end_d;
    logic [ChunkIndexBits-1:0]  cs_chunk_q,    cs_chunk_d;
    logic [CntWidth-1:0]        cs_count_q,    cs_count_d;
    logic [ElpWidth-1:0]        cs_elp_q,      cs_elp_d;

    // per-chunk views of the snapshot
    logic [CntWidth-1:0]        count_arr [Multi];
    logic [ElpWidth-1:0]        elp_arr   [Multi];

    // fields of the chunk currently addressed by idx_q
    logic                       cur_errored;
    logic                       cur_fail;
    logic [CntWidth-1:0]        cur_count;
    logic [ElpWidth-1:0]        cur_elp;
    logic [Multi-1:0]           cur_onehot;

    // Split the packed snapshot into per-chunk slices (chunk 0 in the LSBs).
    generate
        for (genvar gi = 0; gi < Multi; gi++) begin : g_unpack
            assign count_arr[gi] = count_q[gi*CntWidth +: CntWidth];
            assign elp_arr[gi]   = elp_q[gi*ElpWidth +: ElpWidth];
        end
    endgenerate

    // Select the chunk addressed by idx_q; idx_q == Multi selects nothing.
    always_comb begin
        cur_errored = 1'b0;
        cur_fail    = 1'b0;
        cur_count   = '0;
        cur_elp     = '0;
        cur_onehot  = '0;
        for (int i = 0; i < Multi; i++) begin
            if (idx_q == IdxWidth'(i)) begin
                cur_errored   = errored_q[i];
                cur_fail      = kes_fail_q[i];
                cur_count     = count_arr[i];
                cur_elp       = elp_arr[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

`ifndef CS_ROOT_CHECK_EN
    // Root count has no consumer when the check is compiled out.
    logic unused_root_count;
    assign unused_root_count = ^iCSRootCount;
`endif

    // Next-state and next-output decode for the dispatch walk.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        errored_d     = errored_q;
        kes_fail_d    = kes_fail_q;
        count_d       = count_q;
        elp_d         = elp_q;
        chunk_fail_d  = chunk_fail_q;
        cs_start_d    = 1'b0;
        cluster_end_d = 1'b0;
        cs_chunk_d    = cs_chunk_q;
        cs_count_d    = cs_count_q;
        cs_elp_d      = cs_elp_q;

        case (state_q)
            IDLE: begin
                if (iIntraSharedKESEnd) begin
                    errored_d    = iErroredChunk;
                    kes_fail_d   = iCorrectionFail;
                    count_d      = iClusterErrorCount;
                    elp_d        = iELPCoefficients;
                    chunk_fail_d = '0;
                    idx_d        = '0;
                    state_d      = SCAN;
                end
            end

            SCAN: begin
                if (idx_q == IdxWidth'(Multi)) begin
                    state_d = REPORT;
                end else if (cur_errored && !cur_fail && (cur_count != '0)) begin
                    state_d = ISSUE;
                end else begin
                    // A KES failure is final for this chunk; anything else
                    // not dispatched simply needs no search.
                    if (cur_fail) begin
                        chunk_fail_d = chunk_fail_q | cur_onehot;
                    end
                    idx_d = idx_q + IdxWidth'(1);
                end
            end

            ISSUE: begin
                // Launch data is latched here and held until the next
                // launch, so it stays stable for the whole search.
                if (iCSReady) begin
                    cs_start_d = 1'b1;
                    cs_chunk_d = ChunkIndexBits'(idx_q);
                    cs_count_d = cur_count;
                    cs_elp_d   = cur_elp;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (iCSDone) begin
`ifdef CS_ROOT_CHECK_EN
                    // A degree-t ELP with fewer than t roots in the field
                    // means the codeword is beyond correction.
                    if (iCSRootCount != cs_count_q) begin
                        chunk_fail_d = chunk_fail_q | cur_onehot;
                    end
`endif
                    idx_d   = idx_q + IdxWidth'(1);
                    state_d = SCAN;
                end
            end

            REPORT: begin
                cluster_end_d = 1'b1;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, snapshot and output registers; reset discards any cluster.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            errored_q     <= '0;
            kes_fail_q    <= '0;
            count_q       <= '0;
            elp_q         <= '0;
            chunk_fail_q  <= '0;
            cs_start_q    <= 1'b0;
            cluster_end_q <= 1'b0;
            cs_chunk_q    <= '0;
            cs_count_q    <= '0;
            cs_elp_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            errored_q     <= errored_d;
            kes_fail_q    <= kes_fail_d;
            count_q       <= count_d;
            elp_q         <= elp_d;
            chunk_fail_q  <= chunk_fail_d;
            cs_start_q    <= cs_start_d;
            cluster_end_q <= cluster_end_d;
            cs_chunk_q    <= cs_chunk_d;
            cs_count_q    <= cs_count_d;
            cs_elp_q      <= cs_elp_d;
        end
    end

    assign oCSAvailable   = (state_q == IDLE);
    assign oCSStart       = cs_start_q;
    assign oCSChunkNumber = cs_chunk_q;
    assign oCSErrorCount  = cs_count_q;
    assign oCSELP         = cs_elp_q;
    assign oClusterEnd    = cluster_end_q;
    assign oChunkFail     = chunk_fail_q;

endmodule

// File: tb/tb_intra_chien_dispatch.sv
// Directed bench for intra_chien_dispatch (Multi=2).
// A negedge monitor records every Chien launch and cluster end; the
// directed sequences compare those records and the outputs against
// hand-computed values. Expectations for the root check follow
// CS_ROOT_CHECK_EN.

module tb_intra_chien_dispatch;

    localparam int M   = 2;
    localparam int GFD = 12;
    localparam int EB  = 9;
    localparam int EC  = 15;
    localparam int CIB = 1;
    localparam int EW  = GFD * EC;

    localparam logic [EW-1:0] ELP0 = {15{12'hA5C}};
    localparam logic [EW-1:0] ELP1 = {15{12'h3F1}};

    // chunk 1 launched with degree 4, search reports 3 roots
    localparam logic [1:0] RC_FAIL =
`ifdef CS_ROOT_CHECK_EN
        2'b10;
`else
        2'b00;
`endif

    logic              iClock = 1'b0;
    logic              iReset = 1'b0;
    logic              iIntraSharedKESEnd = 1'b0;
    logic [M-1:0]      iErroredChunk = '0;
    logic [M-1:0]      iCorrectionFail = '0;
    logic [M*EB-1:0]   iClusterErrorCount = '0;
    logic [M*EW-1:0]   iELPCoefficients = '0;
    logic              oCSAvailable;
    logic              oCSStart;
    logic [CIB-1:0]    oCSChunkNumber;
    logic [EB-1:0]     oCSErrorCount;
    logic [EW-1:0]     oCSELP;
    logic              iCSReady = 1'b1;
    logic              iCSDone = 1'b0;
    logic [EB-1:0]     iCSRootCount = '0;
    logic              oClusterEnd;
    logic [M-1:0]      oChunkFail;

    intra_chien_dispatch #(
        .Multi(M), .GaloisFieldDegree(GFD), .MaxErrorCountBits(EB),
        .ELPCoefficients(EC), .ChunkIndexBits(CIB)
    ) dut (
        .iClock(iClock), .iReset(iReset),
        .iIntraSharedKESEnd(iIntraSharedKESEnd),
        .iErroredChunk(iErroredChunk), .iCorrectionFail(iCorrectionFail),
        .iClusterErrorCount(iClusterErrorCount), .iELPCoefficients(iELPCoefficients),
        .oCSAvailable(oCSAvailable), .oCSStart(oCSStart),
        .oCSChunkNumber(oCSChunkNumber), .oCSErrorCount(oCSErrorCount),
        .oCSELP(oCSELP), .iCSReady(iCSReady), .iCSDone(iCSDone),
        .iCSRootCount(iCSRootCount), .oClusterEnd(oClusterEnd),
        .oChunkFail(oChunkFail)
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int n_start = 0;
    int n_end = 0;
    int end_cyc = 0;
    logic [CIB-1:0] st_chunk [16];
    logic [EB-1:0]  st_count [16];
    logic [EW-1:0]  st_elp   [16];

    always @(posedge iClock) cyc <= cyc + 1;

    // Record launches and cluster ends half a cycle after each edge.
    always @(negedge iClock) begin
        if (oCSStart && n_start < 16) begin
            st_chunk[n_start] <= oCSChunkNumber;
            st_count[n_start] <= oCSErrorCount;
            st_elp[n_start]   <= oCSELP;
        end
        if (oCSStart) n_start <= n_start + 1;
        if (oClusterEnd) begin
            n_end   <= n_end + 1;
            end_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic capture(input logic [1:0] err, input logic [1:0] fl,
                           input logic [EB-1:0] c0, input logic [EB-1:0] c1);
        iErroredChunk      = err;
        iCorrectionFail    = fl;
        iClusterErrorCount = {c1, c0};
        iELPCoefficients   = {ELP1, ELP0};
        iIntraSharedKESEnd = 1'b1;
        @(posedge iClock);
        #1;
        cap_cyc = cyc;
        iIntraSharedKESEnd = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n0 = n_start;
        int k = 0;
        while (n_start == n0 && k < 60) begin
            tick(1);
            k++;
        end
        check({tag, "_start_seen"}, 192'(n_start != n0), 192'(1));
    endtask

    task automatic wait_end(input string tag);
        int n0 = n_end;
        int k = 0;
        while (n_end == n0 && k < 60) begin
            tick(1);
            k++;
        end
        check({tag, "_end_seen"}, 192'(n_end != n0), 192'(1));
    endtask

    task automatic serve(input logic [EB-1:0] root, input int dly);
        tick(dly);
        iCSRootCount = root;
        iCSDone = 1'b1;
        tick(1);
        iCSDone = 1'b0;
        iCSRootCount = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        int e0;

        // reset values
        tick(3);
        check("rst_avail",  192'(oCSAvailable), 192'(1));
        check("rst_start",  192'(oCSStart), 192'(0));
        check("rst_end",    192'(oClusterEnd), 192'(0));
        check("rst_fail",   192'(oChunkFail), 192'(0));
        check("rst_chunk",  192'(oCSChunkNumber), 192'(0));
        check("rst_count",  192'(oCSErrorCount), 192'(0));
        check("rst_elp",    192'(oCSELP), 192'(0));
        iReset = 1'b1;
        tick(2);

        // nothing errored: pure scan, end at capture+4
        s0 = n_start;
        capture(2'b00, 2'b00, 9'd0, 9'd0);
        check("t1_busy", 192'(oCSAvailable), 192'(0));
        wait_end("t1");
        check("t1_latency", 192'(end_cyc - cap_cyc), 192'(4));
        check("t1_nstart",  192'(n_start - s0), 192'(0));
        check("t1_fail",    192'(oChunkFail), 192'(0));
        check("t1_avail",   192'(oCSAvailable), 192'(1));

        // single chunk 0, degree 3, three roots found
        s0 = n_start;
        capture(2'b01, 2'b00, 9'd3, 9'd5);
        wait_start("t2");
        check("t2_chunk", 192'(st_chunk[s0]), 192'(0));
        check("t2_count", 192'(st_count[s0]), 192'(3));
        check("t2_elp",   192'(st_elp[s0]), 192'(ELP0));
        tick(3);
        check("t2_hold_count", 192'(oCSErrorCount), 192'(3));
        check("t2_hold_elp",   192'(oCSELP), 192'(ELP0));
        serve(9'd3, 0);
        wait_end("t2");
        check("t2_nstart", 192'(n_start - s0), 192'(1));
        check("t2_fail",   192'(oChunkFail), 192'(0));

        // both chunks, degrees 2/4, roots 2/3
        s0 = n_start;
        capture(2'b11, 2'b00, 9'd2, 9'd4);
        wait_start("t3a");
        serve(9'd2, 1);
        wait_start("t3b");
        serve(9'd3, 1);
        wait_end("t3");
        check("t3_nstart", 192'(n_start - s0), 192'(2));
        check("t3_chunk0", 192'(st_chunk[s0]), 192'(0));
        check("t3_count0", 192'(st_count[s0]), 192'(2));
        check("t3_chunk1", 192'(st_chunk[s0+1]), 192'(1));
        check("t3_count1", 192'(st_count[s0+1]), 192'(4));
        check("t3_elp1",   192'(st_elp[s0+1]), 192'(ELP1));
        check("t3_fail",   192'(oChunkFail), 192'(RC_FAIL));

        // chunk 1 failed in KES: no launch, flagged, still Multi+2 latency
        s0 = n_start;
        capture(2'b10, 2'b10, 9'd0, 9'd7);
        wait_end("t4");
        check("t4_nstart",  192'(n_start - s0), 192'(0));
        check("t4_fail",    192'(oChunkFail), 192'(2'b10));
        check("t4_latency", 192'(end_cyc - cap_cyc), 192'(4));

        // engine busy for 5 cycles; second hand-off during WAIT ignored
        s0 = n_start;
        e0 = n_end;
        iCSReady = 1'b0;
        capture(2'b01, 2'b00, 9'd1, 9'd0);
        check("t5_fail_cleared", 192'(oChunkFail), 192'(0));
        tick(5);
        check("t5_held_nstart", 192'(n_start - s0), 192'(0));
        check("t5_held_avail",  192'(oCSAvailable), 192'(0));
        iCSReady = 1'b1;
        wait_start("t5");
        check("t5_chunk", 192'(st_chunk[s0]), 192'(0));
        iErroredChunk = 2'b11;
        iClusterErrorCount = {9'd6, 9'd6};
        iIntraSharedKESEnd = 1'b1;
        tick(1);
        iIntraSharedKESEnd = 1'b0;
        check("t5_wait_avail", 192'(oCSAvailable), 192'(0));
        serve(9'd1, 1);
        wait_end("t5");
        tick(10);
        check("t5_nstart", 192'(n_start - s0), 192'(1));
        check("t5_nend",   192'(n_end - e0), 192'(1));
        check("t5_avail",  192'(oCSAvailable), 192'(1));

        // reset while waiting on the engine
        s0 = n_start;
        e0 = n_end;
        capture(2'b01, 2'b00, 9'd3, 9'd0);
        wait_start("t6");
        iReset = 1'b0;
        #1;
        check("t6_rst_avail", 192'(oCSAvailable), 192'(1));
        check("t6_rst_count", 192'(oCSErrorCount), 192'(0));
        check("t6_rst_elp",   192'(oCSELP), 192'(0));
        tick(1);
        iReset = 1'b1;
        tick(1);
        serve(9'd3, 0);
        tick(8);
        check("t6_nend",   192'(n_end - e0), 192'(0));
        check("t6_nstart", 192'(n_start - s0), 192'(1));
        check("t6_avail",  192'(oCSAvailable), 192'(1));

        // errored but degree 0: not dispatched
        s0 = n_start;
        capture(2'b01, 2'b00, 9'd0, 9'd0);
        wait_end("t7");
        check("t7_nstart",  192'(n_start - s0), 192'(0));
        check("t7_fail",    192'(oChunkFail), 192'(0));
        check("t7_latency", 192'(end_cyc - cap_cyc), 192'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
